// File: rtl/ctx_restore_pkg.sv
// ctx_restore_pkg
//   Shared map of the context shadow image in SRAM. It holds the region ids,
//   the base address and index mask of each region, and the MMIO window
//   register offsets. Both the context writer and the read-back side
//   (ctx_restore) import it so the shadow layout is defined in one place.
//   No ports: types, constants and helper functions only.
package ctx_restore_pkg;

  localparam int IDX_W = 17;

  typedef enum logic [1:0] {
    REGION_WRAM = 2'd0,
    REGION_VRAM = 2'd1,
    REGION_APU  = 2'd2,
    REGION_PPU  = 2'd3
  } region_e;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT
  } fetch_state_e;

  localparam logic [23:0] BASE_WRAM = 24'hF50000;
  localparam logic [23:0] BASE_VRAM = 24'hF70000;
  localparam logic [23:0] BASE_APU  = 24'hF80000;
  localparam logic [23:0] BASE_PPU  = 24'hF90000;

  localparam logic [IDX_W-1:0] MASK_WRAM = 17'h1FFFF;
  localparam logic [IDX_W-1:0] MASK_VRAM = 17'h0FFFF;
  localparam logic [IDX_W-1:0] MASK_APU  = 17'h0FFFF;
  localparam logic [IDX_W-1:0] MASK_PPU  = 17'h007FF;

  localparam logic [2:0] OFS_IDX_LO  = 3'd0;
  localparam logic [2:0] OFS_IDX_HI  = 3'd1;
  localparam logic [2:0] OFS_IDX_EXT = 3'd2;
  localparam logic [2:0] OFS_DATA    = 3'd3;
  localparam logic [2:0] OFS_STATUS  = 3'd4;

  function automatic logic [23:0] region_base(input region_e r);
    logic [23:0] b;
    case (r)
      REGION_WRAM: b = BASE_WRAM;
      REGION_VRAM: b = BASE_VRAM;
      REGION_APU:  b = BASE_APU;
      default:     b = BASE_PPU;
    endcase
    return b;
  endfunction

  function automatic logic [IDX_W-1:0] region_mask(input region_e r);
    logic [IDX_W-1:0] m;
    case (r)
      REGION_WRAM: m = MASK_WRAM;
      REGION_VRAM: m = MASK_VRAM;
      REGION_APU:  m = MASK_APU;
      default:     m = MASK_PPU;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ctx_pf_fifo.sv
// ctx_pf_fifo
//   Small synchronous prefetch FIFO, DEPTH x 8 bits (DEPTH a power of 2).
//   Ports:
//     clkin, reset        clock, synchronous active-high reset
//     push, push_data     write one byte (ignored when full unless popping too)
//     pop                 drop the head byte (ignored when empty)
//     flush               empty the FIFO; has priority over push/pop
//     head                current head byte (undefined when empty)
//     count, empty, full  occupancy
module ctx_pf_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clkin,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is allowed only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clkin) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ctx_restore.sv
// ctx_restore
//   Read-back side of the context shadow image. The SNES selects a region and
//   index through an 8-byte MMIO window and streams bytes out of the shadow
//   SRAM through an auto-incrementing data port. A prefetch FIFO, fed by one
//   outstanding SRAM read at a time, hides the SRAM latency.
//   Ports:
//     clkin, reset                  clock, synchronous active-high reset
//     SNES_ADDR                     SNES CPU address
//     SNES_RD_end, SNES_WR_end      one-cycle end-of-access strobes
//     SNES_DATA_IN / SNES_DATA_OUT  write data in / window read data out
//     OE_RD_ENABLE                  address is the data port or status register
//     BUS_RRQ, BUS_RDY              read request pulse / arbiter ready
//     ROM_ADDR                      SRAM read address of the current request
//     RD_DATA, RD_VALID             SRAM read return
module ctx_restore
  import ctx_restore_pkg::*;
#(
  parameter int          PF_DEPTH = 4,
  parameter logic [15:0] WIN_BASE = 16'h2BF8
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic [23:0] SNES_ADDR,
  input  logic        SNES_RD_end,
  input  logic        SNES_WR_end,
  input  logic [7:0]  SNES_DATA_IN,
  output logic [7:0]  SNES_DATA_OUT,
  output logic        OE_RD_ENABLE,
  output logic        BUS_RRQ,
  input  logic        BUS_RDY,
  output logic [23:0] ROM_ADDR,
  input  logic [7:0]  RD_DATA,
  input  logic        RD_VALID
);

  localparam int CW = $clog2(PF_DEPTH) + 1;

  logic [15:0]      win_ofs;
  logic             win_hit;
  logic [2:0]       ofs;
  logic             data_sel;
  logic             status_sel;
  logic             cfg_wr;

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_new;
  region_e          region;
  region_e          region_new;
  logic [IDX_W-1:0] fp;
  logic             discard;
  logic             underrun;

  fetch_state_e     state;
  fetch_state_e     state_next;
  logic             grant;
  logic             accept;

  logic             pf_push;
  logic             pf_pop;
  logic [7:0]       pf_head;
  logic [CW-1:0]    pf_count;
  logic             pf_empty;
  logic             pf_full;
  logic [3:0]       cnt_ext;
  logic [7:0]       status;

  logic             unused_bits;

  // Window decode: banks with A22 clear, 8 consecutive bytes from WIN_BASE.
  assign win_ofs    = SNES_ADDR[15:0] - WIN_BASE;
  assign win_hit    = !SNES_ADDR[22] && (win_ofs < 16'd8);
  assign ofs        = win_ofs[2:0];
  assign data_sel   = win_hit && (ofs == OFS_DATA);
  assign status_sel = win_hit && (ofs == OFS_STATUS);
  assign cfg_wr     = SNES_WR_end && win_hit &&
                      ((ofs == OFS_IDX_LO) || (ofs == OFS_IDX_HI) || (ofs == OFS_IDX_EXT));

  assign OE_RD_ENABLE = data_sel || status_sel;

  // Index/region value after the current config write, so the fetch pointer
  // can be reseeded in the same cycle.
  always_comb begin
    idx_new    = idx;
    region_new = region;
    if (cfg_wr) begin
      case (ofs)
        OFS_IDX_LO:  idx_new[7:0]  = SNES_DATA_IN;
        OFS_IDX_HI:  idx_new[15:8] = SNES_DATA_IN;
        OFS_IDX_EXT: begin
          idx_new[16] = SNES_DATA_IN[7];
          region_new  = region_e'(SNES_DATA_IN[1:0]);
        end
        default: ;
      endcase
    end
  end

  assign grant   = (state == FETCH_REQ) && BUS_RDY;
  assign accept  = (state == FETCH_WAIT) && RD_VALID;
  assign BUS_RRQ = grant;

  always_ff @(posedge clkin) begin
    if (reset) begin
      state <= FETCH_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A config write abandons a pending request, but if the arbiter grants it
  // in that same cycle the read is already on the bus: it still goes to
  // WAIT and the return is discarded.
  always_comb begin
    state_next = state;
    case (state)
      FETCH_IDLE: if (!cfg_wr && !pf_full) state_next = FETCH_REQ;
      FETCH_REQ: begin
        if (grant) begin
          state_next = FETCH_WAIT;
        end else if (cfg_wr) begin
          state_next = FETCH_IDLE;
        end
      end
      FETCH_WAIT: if (RD_VALID) state_next = FETCH_IDLE;
      default:    state_next = FETCH_IDLE;
    endcase
  end

  // Index, fetch pointer, request address and the sticky flags.
  always_ff @(posedge clkin) begin
    if (reset) begin
      idx      <= '0;
      region   <= REGION_WRAM;
      fp       <= '0;
      ROM_ADDR <= '0;
      discard  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      idx    <= idx_new;
      region <= region_new;

      if (cfg_wr) begin
        fp <= idx_new & region_mask(region_new);
      end else if (grant) begin
        fp <= (fp + 1'b1) & region_mask(region);
      end

      if ((state == FETCH_IDLE) && (state_next == FETCH_REQ)) begin
        ROM_ADDR <= region_base(region) + {7'd0, fp};
      end

      // The read still in flight after a config write belongs to the old index.
      if (cfg_wr) begin
        discard <= (state_next == FETCH_WAIT);
      end else if (accept) begin
        discard <= 1'b0;
      end

      if (SNES_RD_end && data_sel && pf_empty) begin
        underrun <= 1'b1;
      end else if (SNES_RD_end && status_sel) begin
        underrun <= 1'b0;
      end
    end
  end

  assign pf_push = accept && !discard && !cfg_wr;
  assign pf_pop  = SNES_RD_end && data_sel;

  ctx_pf_fifo #(
    .DEPTH (PF_DEPTH)
  ) u_pf_fifo (
    .clkin     (clkin),
    .reset     (reset),
    .push      (pf_push),
    .push_data (RD_DATA),
    .pop       (pf_pop),
    .flush     (cfg_wr),
    .head      (pf_head),
    .count     (pf_count),
    .empty     (pf_empty),
    .full      (pf_full)
  );

  assign cnt_ext = 4'(pf_count);
  assign status  = {pf_empty, underrun, 3'b000, cnt_ext[2:0]};

  always_comb begin
    SNES_DATA_OUT = 8'h00;
    if (data_sel) begin
      SNES_DATA_OUT = pf_empty ? 8'h00 : pf_head;
    end else if (status_sel) begin
      SNES_DATA_OUT = status;
    end
  end

  assign unused_bits = &{1'b0, SNES_ADDR[23], SNES_ADDR[21:16], SNES_DATA_IN[6:2], cnt_ext[3]};

endmodule

// File: tb/tb_ctx_restore.sv
// tb_ctx_restore
//   Directed bench for ctx_restore. The bench also plays the SRAM arbiter:
//   it logs every BUS_RRQ address and answers after arb_latency cycles with
//   a byte derived from the address (low nibble n -> {n+1, n+1}).
module tb_ctx_restore;

  logic        clkin = 1'b0;
  logic        reset;
  logic [23:0] SNES_ADDR;
  logic        SNES_RD_end;
  logic        SNES_WR_end;
  logic [7:0]  SNES_DATA_IN;
  logic [7:0]  SNES_DATA_OUT;
  logic        OE_RD_ENABLE;
  logic        BUS_RRQ;
  logic        BUS_RDY;
  logic [23:0] ROM_ADDR;
  logic [7:0]  RD_DATA = 8'h00;
  logic        RD_VALID = 1'b0;

  int compares = 0;
  int fails = 0;

  int          arb_latency = 3;
  int          arb_pend = 0;
  logic [23:0] arb_addr = 24'h0;
  int          rrq_count = 0;
  logic [23:0] req_log[$];

  always #5 clkin = ~clkin;

  ctx_restore dut (
    .clkin         (clkin),
    .reset         (reset),
    .SNES_ADDR     (SNES_ADDR),
    .SNES_RD_end   (SNES_RD_end),
    .SNES_WR_end   (SNES_WR_end),
    .SNES_DATA_IN  (SNES_DATA_IN),
    .SNES_DATA_OUT (SNES_DATA_OUT),
    .OE_RD_ENABLE  (OE_RD_ENABLE),
    .BUS_RRQ       (BUS_RRQ),
    .BUS_RDY       (BUS_RDY),
    .ROM_ADDR      (ROM_ADDR),
    .RD_DATA       (RD_DATA),
    .RD_VALID      (RD_VALID)
  );

  function automatic logic [7:0] sram_model(input logic [23:0] a);
    logic [3:0] n;
    n = a[3:0] + 4'd1;
    return {n, n};
  endfunction

  // Arbiter/SRAM model, sampled on the falling edge.
  always @(negedge clkin) begin
    RD_VALID = 1'b0;
    if (arb_pend > 0) begin
      arb_pend--;
      if (arb_pend == 0) begin
        RD_VALID = 1'b1;
        RD_DATA  = sram_model(arb_addr);
      end
    end
    if (BUS_RRQ) begin
      rrq_count++;
      req_log.push_back(ROM_ADDR);
      arb_addr = ROM_ADDR;
      arb_pend = arb_latency;
    end
  end

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic snes_write(input logic [23:0] a, input logic [7:0] d);
    SNES_ADDR    = a;
    SNES_DATA_IN = d;
    SNES_WR_end  = 1'b1;
    tick();
    SNES_WR_end  = 1'b0;
    SNES_ADDR    = 24'h0;
  endtask

  task automatic snes_read(input logic [23:0] a, output logic [7:0] d);
    SNES_ADDR = a;
    #1;
    d = SNES_DATA_OUT;
    SNES_RD_end = 1'b1;
    tick();
    SNES_RD_end = 1'b0;
    SNES_ADDR   = 24'h0;
  endtask

  task automatic peek(input logic [23:0] a, output logic [7:0] d);
    SNES_ADDR = a;
    #1;
    d = SNES_DATA_OUT;
    SNES_ADDR = 24'h0;
  endtask

  function automatic logic [23:0] log_at(input int i);
    if (i < req_log.size()) return req_log[i];
    return 24'hxxxxxx;
  endfunction

  task automatic wait_count(input int n, input int max_cycles, input string what);
    logic [7:0] st;
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < max_cycles; k++) begin
      peek(24'h002BFC, st);
      if (int'(st[2:0]) >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    compares++;
    if (!ok) begin fails++; $display("[TB] FAIL %s_timeout: fifo count %0d, required >= %0d", what, st[2:0], n); end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b1; BUS_RDY = 1'b0; SNES_ADDR = 24'h0;
    SNES_RD_end = 1'b0; SNES_WR_end = 1'b0; SNES_DATA_IN = 8'h00;
    repeat (3) tick();
    compares++; if (BUS_RRQ !== 1'b0) begin fails++; $display("[TB] FAIL reset_rrq: got %0h, required 0", BUS_RRQ); end
    compares++; if (ROM_ADDR !== 24'h000000) begin fails++; $display("[TB] FAIL reset_rom_addr: got %h, required 000000", ROM_ADDR); end
    peek(24'h002BFC, d);
    compares++; if (d !== 8'h80) begin fails++; $display("[TB] FAIL reset_status: got %h, required 80", d); end
    peek(24'h002BFB, d);
    compares++; if (d !== 8'h00) begin fails++; $display("[TB] FAIL reset_data: got %h, required 00", d); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_decode();
    logic [23:0] addrs [8];
    logic        oe_exp [8];
    logic [7:0]  d;
    addrs  = '{24'h002BFB, 24'h002BFC, 24'h002BFA, 24'h402BFB,
               24'h802BFC, 24'h7E2BFB, 24'h002BFD, 24'h002C03};
    oe_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      SNES_ADDR = addrs[i];
      #1;
      compares++; if (OE_RD_ENABLE !== oe_exp[i]) begin fails++; $display("[TB] FAIL decode_oe[%h]: got %0h, required %0h", addrs[i], OE_RD_ENABLE, oe_exp[i]); end
    end
    peek(24'h402BFC, d);
    compares++; if (d !== 8'h00) begin fails++; $display("[TB] FAIL decode_outside: got %h, required 00", d); end
    peek(24'h802BFC, d);
    compares++; if (d !== 8'h80) begin fails++; $display("[TB] FAIL decode_mirror_status: got %h, required 80", d); end
    tick();
  endtask

  task automatic test_first_fetch();
    logic [7:0] d;
    snes_write(24'h002BFA, 8'h01);
    snes_write(24'h002BF8, 8'h10);
    snes_write(24'h002BF9, 8'h00);
    tick(); tick();
    compares++; if (ROM_ADDR !== 24'hF70010) begin fails++; $display("[TB] FAIL first_rom_addr: got %h, required F70010", ROM_ADDR); end
    compares++; if (rrq_count !== 0) begin fails++; $display("[TB] FAIL first_no_rrq_yet: got %0d, required 0", rrq_count); end
    BUS_RDY = 1'b1;
    #1;
    compares++; if (BUS_RRQ !== 1'b1) begin fails++; $display("[TB] FAIL first_rrq_pulse: got %0h, required 1", BUS_RRQ); end
    tick();
    BUS_RDY = 1'b0;
    wait_count(1, 20, "first");
    compares++; if (rrq_count !== 1) begin fails++; $display("[TB] FAIL first_rrq_count: got %0d, required 1", rrq_count); end
    compares++; if (log_at(0) !== 24'hF70010) begin fails++; $display("[TB] FAIL first_req_addr: got %h, required F70010", log_at(0)); end
    peek(24'h002BFC, d);
    compares++; if (d !== 8'h01) begin fails++; $display("[TB] FAIL first_status: got %h, required 01", d); end
    peek(24'h002BFB, d);
    compares++; if (d !== 8'h11) begin fails++; $display("[TB] FAIL first_head: got %h, required 11", d); end
  endtask

  task automatic test_fill();
    logic [7:0] d;
    BUS_RDY = 1'b1;
    wait_count(4, 60, "fill");
    repeat (15) tick();
    compares++; if (rrq_count !== 4) begin fails++; $display("[TB] FAIL fill_rrq_count: got %0d, required 4", rrq_count); end
    for (int i = 0; i < 4; i++) begin
      compares++; if (log_at(i) !== 24'hF70010 + 24'(i)) begin fails++; $display("[TB] FAIL fill_addr[%0d]: got %h, required %h", i, log_at(i), 24'hF70010 + 24'(i)); end
    end
    peek(24'h002BFC, d);
    compares++; if (d !== 8'h04) begin fails++; $display("[TB] FAIL fill_status_full: got %h, required 04", d); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [4];
    logic [7:0] d;
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      snes_read(24'h002BFB, d);
      compares++; if (d !== exp[i]) begin fails++; $display("[TB] FAIL b2b_data[%0d]: got %h, required %h", i, d, exp[i]); end
    end
    wait_count(4, 80, "refill");
    repeat (10) tick();
    compares++; if (rrq_count !== 8) begin fails++; $display("[TB] FAIL refill_rrq_count: got %0d, required 8", rrq_count); end
    for (int i = 4; i < 8; i++) begin
      compares++; if (log_at(i) !== 24'hF70010 + 24'(i)) begin fails++; $display("[TB] FAIL refill_addr[%0d]: got %h, required %h", i, log_at(i), 24'hF70010 + 24'(i)); end
    end
    snes_read(24'h002BFB, d);
    compares++; if (d !== 8'h55) begin fails++; $display("[TB] FAIL refill_data: got %h, required 55", d); end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    int base;
    BUS_RDY = 1'b0;
    repeat (10) tick();
    snes_write(24'h002BFA, 8'h03);
    snes_write(24'h002BF8, 8'hFF);
    snes_write(24'h002BF9, 8'h07);
    base = req_log.size();
    BUS_RDY = 1'b1;
    wait_count(2, 40, "wrap_ppu");
    BUS_RDY = 1'b0;
    compares++; if (log_at(base) !== 24'hF907FF) begin fails++; $display("[TB] FAIL wrap_ppu_first: got %h, required F907FF", log_at(base)); end
    compares++; if (log_at(base+1) !== 24'hF90000) begin fails++; $display("[TB] FAIL wrap_ppu_second: got %h, required F90000", log_at(base+1)); end
    snes_read(24'h002BFB, d);
    compares++; if (d !== 8'h00) begin fails++; $display("[TB] FAIL wrap_ppu_data0: got %h, required 00", d); end
    snes_read(24'h002BFB, d);
    compares++; if (d !== 8'h11) begin fails++; $display("[TB] FAIL wrap_ppu_data1: got %h, required 11", d); end

    // WRAM is 128 KiB: index 1FFFF lands on F50000 + 1FFFF = F6FFFF.
    repeat (10) tick();
    snes_write(24'h002BFA, 8'h80);
    snes_write(24'h002BF8, 8'hFF);
    snes_write(24'h002BF9, 8'hFF);
    base = req_log.size();
    BUS_RDY = 1'b1;
    wait_count(2, 40, "wrap_wram");
    BUS_RDY = 1'b0;
    compares++; if (log_at(base) !== 24'hF6FFFF) begin fails++; $display("[TB] FAIL wrap_wram_first: got %h, required F6FFFF", log_at(base)); end
    compares++; if (log_at(base+1) !== 24'hF50000) begin fails++; $display("[TB] FAIL wrap_wram_second: got %h, required F50000", log_at(base+1)); end
  endtask

  task automatic test_underrun();
    logic [7:0] d;
    BUS_RDY = 1'b0;
    repeat (10) tick();
    snes_write(24'h002BF8, 8'h00);
    tick();
    peek(24'h002BFC, d);
    compares++; if (d !== 8'h80) begin fails++; $display("[TB] FAIL underrun_pre_status: got %h, required 80", d); end
    snes_read(24'h002BFB, d);
    compares++; if (d !== 8'h00) begin fails++; $display("[TB] FAIL underrun_data: got %h, required 00", d); end
    snes_read(24'h002BFC, d);
    compares++; if (d !== 8'hC0) begin fails++; $display("[TB] FAIL underrun_status_set: got %h, required C0", d); end
    snes_read(24'h002BFC, d);
    compares++; if (d !== 8'h80) begin fails++; $display("[TB] FAIL underrun_status_clr: got %h, required 80", d); end
  endtask

  task automatic test_discard();
    logic [7:0] d;
    int base;
    arb_latency = 6;
    snes_write(24'h002BFA, 8'h01);
    snes_write(24'h002BF8, 8'h23);
    snes_write(24'h002BF9, 8'h00);
    tick(); tick();
    base = req_log.size();
    BUS_RDY = 1'b1;
    tick();
    BUS_RDY = 1'b0;
    compares++; if (log_at(base) !== 24'hF70023) begin fails++; $display("[TB] FAIL discard_old_req: got %h, required F70023", log_at(base)); end
    snes_write(24'h002BF8, 8'h45);
    BUS_RDY = 1'b1;
    wait_count(1, 40, "discard");
    BUS_RDY = 1'b0;
    compares++; if (log_at(base+1) !== 24'hF70045) begin fails++; $display("[TB] FAIL discard_new_req: got %h, required F70045", log_at(base+1)); end
    peek(24'h002BFB, d);
    compares++; if (d !== 8'h66) begin fails++; $display("[TB] FAIL discard_head: got %h, required 66", d); end
    peek(24'h002BFC, d);
    compares++; if (d !== 8'h01) begin fails++; $display("[TB] FAIL discard_status: got %h, required 01", d); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    int base;
    bit rrq_seen;
    BUS_RDY = 1'b0;
    repeat (12) tick();
    snes_write(24'h002BF8, 8'h00);
    tick(); tick();
    arb_latency = 6;
    base = rrq_count;
    BUS_RDY = 1'b1;
    tick();
    BUS_RDY = 1'b0;
    reset = 1'b1;
    compares++; if (rrq_count !== base + 1) begin fails++; $display("[TB] FAIL midrst_req_issued: got %0d, required %0d", rrq_count, base + 1); end
    tick(); tick();
    reset = 1'b0;
    rrq_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (BUS_RRQ !== 1'b0) rrq_seen = 1'b1;
      tick();
    end
    compares++; if (rrq_seen !== 1'b0) begin fails++; $display("[TB] FAIL midrst_rrq_quiet: got %0h, required 0", rrq_seen); end
    compares++; if (rrq_count !== base + 1) begin fails++; $display("[TB] FAIL midrst_rrq_count: got %0d, required %0d", rrq_count, base + 1); end
    peek(24'h002BFC, d);
    compares++; if (d !== 8'h80) begin fails++; $display("[TB] FAIL midrst_status: got %h, required 80", d); end
    compares++; if (ROM_ADDR !== 24'hF50000) begin fails++; $display("[TB] FAIL midrst_rom_addr: got %h, required F50000", ROM_ADDR); end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_decode();
    test_first_fetch();
    test_fill();
    test_back_to_back();
    test_wrap();
    test_underrun();
    test_discard();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
